muladd_model: RTL
=================

Name: muladd_model

Overview:
- Cycle-accurate RTL behavioural model of the 8x8 multiply-add hard block.
- It is the cell that the `$mul` techmap instantiates.
- Serves as the simulation model for post-techmap equivalence checks and as the synthesizable soft fallback on fabrics without the hard block.
- Implements every ConfigBits mode: input registers, C register, accumulator, signed product and output register. The techmap currently uses only mode 6'b000000.

Parameters:
- ConfigBits, 6'b000000: bit0 A_REG, bit1 B_REG, bit2 C_REG, bit3 ACC, bit4 SIGNED, bit5 Q_REG.
- A_W, 8: multiplier operand width. Fixed; changing it is unsupported.
- C_W, 20: addend, accumulator and Q width.

Ports:
- CLK  in  1  fabric user clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CE  in  1  clock enable for every internal register.
- CLR  in  1  synchronous accumulator load; ACC mode only.
- A  in  8  multiplicand.
- B  in  8  multiplier.
- C  in  20  addend, or accumulator preload value.
- Q  out  20  result.

Behaviour:
- Reset: all internal registers (A_q, B_q, C_q, acc_q, Q_q) clear to 0 asynchronously on RST_N low. Release is synchronous to CLK.
- Reset, registered paths: any registered Q reads 0 while in reset.
- Reset, combinational paths: a combinational Q follows its inputs even during reset, with registered operands reading 0.
- Operand select:
  - a = A_REG ? A_q : A; b = B_REG ? B_q : B; c = C_REG ? C_q : C.
  - A_q, B_q and C_q load when CE=1.
- Product: p = a*b, 16 bits.
  - SIGNED=1: a and b are two's complement; p is sign-extended to 20 bits.
  - SIGNED=0: unsigned operands; p is zero-extended.
  - Mixed signedness is not supported; the techmap fails mixed cases.
- Non-ACC mode (bit3=0):
  - s = c + p mod 2^20.
  - Q = Q_REG ? Q_q : s; Q_q <= s when CE=1.
  - CLR is ignored.
- ACC mode (bit3=1):
  - On CE=1: acc_q <= CLR ? (c + p) : (acc_q + p), mod 2^20.
  - Q = acc_q. Q_REG is ignored because the output is inherently registered.
  - c enters only on CLR cycles.
- Latency, A/B to Q: A_REG|B_REG (1 if either is set) + (ACC | Q_REG). Mode 000000 is purely combinational, 0 cycles.
- Latency, C to Q: C_REG + (ACC | Q_REG).
- Unequal input registering (e.g. A_REG=1, B_REG=0) is legal. Operands are then skewed by one cycle, and the model reproduces that skew exactly.
- CE=0: every register holds, including acc_q. CLR with CE=0 has no effect.
- Overflow: wraps modulo 2^20. No saturation, no flag.
- Reset mid-accumulation: acc_q is 0 immediately. The first CE cycle after release without CLR yields Q = p.
- X on A or B while the corresponding register is enabled and CE=0 must not propagate.

Decomposition:
- Package muladd_pkg:
  - localparams CFG_A_REG=0, CFG_B_REG=1, CFG_C_REG=2, CFG_ACC=3, CFG_SIGNED=4, CFG_Q_REG=5.
  - MUL_W=8, PROD_W=16, ACC_W=20.
  - Function prod_ext(a, b, signed) returning ACC_W bits.
- Sub-module muladd_opt_reg:
  - Parameters W and BYPASS.
  - Async active-low clear plus CE.
  - Instanced for the A, B, C and Q paths. The accumulator stays inline.

Test Plan:
- Cfg 000000, A=8'hFF, B=8'hFF, C=0 -> Q=20'h0FE01 in the same cycle. Then C=20'h0001F -> Q=20'h0FE20.
- Cfg 010000 (SIGNED), A=8'hFF (-1), B=8'h03, C=20'h00010 -> Q=20'h0000D. With A=8'h80, B=8'h80, C=0 -> Q=20'h04000.
- Cfg 001000 (ACC):
  - Cycle 0: CLR=1, C=20'h00100, A=2, B=3 -> Q=20'h00106 after 1 edge.
  - Next 3 cycles: A=2, B=3, CLR=0 -> Q=20'h0010C, 20'h00112, 20'h00118.
  - Then CE=0 for 2 cycles -> Q holds 20'h00118.
- Cfg 001000: CLR with C=20'hFFFF0, then A=4, B=5 -> Q=20'h00004 on the following cycle (wrap). Assert RST_N=0 mid-stream -> Q=0 without a clock edge.
- Cfg 100111 (A/B/C regs + Q_REG): A=10, B=10, C=5 applied for one cycle, then inputs zeroed -> Q=0 for the first edge, Q=20'h00069 after the second edge, Q=0 after the third.
- Cfg 000001 (A_REG only): A sequence 1,2,3 with B sequence 7,8,9 -> Q after each edge = 1*8=8, then 2*9=18, confirming the one-cycle skew.

Source files
------------

// File: rtl/muladd_pkg.sv
// muladd_pkg: shared constants and the product helper for the 8x8 multiply-add model.
//   CFG_*  : bit positions inside the ConfigBits mode word
//   MUL_W / PROD_W / ACC_W : operand, raw product and accumulator/result widths
//   prod_ext : 8x8 product extended to ACC_W, signed or unsigned
package muladd_pkg;

  localparam int CFG_A_REG  = 0;
  localparam int CFG_B_REG  = 1;
  localparam int CFG_C_REG  = 2;
  localparam int CFG_ACC    = 3;
  localparam int CFG_SIGNED = 4;
  localparam int CFG_Q_REG  = 5;

  localparam int MUL_W  = 8;
  localparam int PROD_W = 16;
  localparam int ACC_W  = 20;

  // Both operands share one signedness; mixed cases never reach this block.
  function automatic logic [ACC_W-1:0] prod_ext(input logic [MUL_W-1:0] a,
                                                input logic [MUL_W-1:0] b,
                                                input logic             sgn);
    logic signed [PROD_W-1:0] ps;
    logic        [PROD_W-1:0] pu;
    ps = PROD_W'($signed(a)) * PROD_W'($signed(b));
    pu = PROD_W'(a) * PROD_W'(b);
    if (sgn) prod_ext = {{(ACC_W-PROD_W){ps[PROD_W-1]}}, ps};
    else     prod_ext = {{(ACC_W-PROD_W){1'b0}}, pu};
  endfunction

endpackage

// File: rtl/muladd_opt_reg.sv
// muladd_opt_reg: optional pipeline register on one datapath.
//   BYPASS=1 : q follows d combinationally (clock, reset, ce unused)
//   BYPASS=0 : q is a CE-gated flop cleared asynchronously by rst_n low
// Ports: clk, rst_n (async active-low), ce, d[W], q[W].
module muladd_opt_reg #(
  parameter int W      = 8,
  parameter bit BYPASS = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (BYPASS) begin : g_comb
      logic unused_ctl;
      assign unused_ctl = &{1'b0, clk, rst_n, ce};
      assign q = d;
    end else begin : g_reg
      logic [W-1:0] q_q, q_d;

      // Holding on CE=0 keeps an X on d out of the register.
      always_comb q_d = ce ? d : q_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
      end

      assign q = q_q;
    end
  endgenerate

endmodule

// File: rtl/muladd_model.sv
// muladd_model: cycle-accurate model of the 8x8 multiply-add hard block.
//   ConfigBits selects A/B/C input registers, accumulate mode, signed product
//   and output register. Q = c + a*b (or the accumulator), wrapping mod 2^C_W.
// Ports:
//   CLK    rising-edge clock          RST_N  async active-low clear of all state
//   CE     enable for every register  CLR    accumulator load (ACC mode only)
//   A, B   8-bit operands             C      addend / accumulator preload
//   Q      result
module muladd_model
  import muladd_pkg::*;
#(
  parameter logic [5:0] ConfigBits = 6'b000000,
  parameter int         A_W        = MUL_W,
  parameter int         C_W        = ACC_W
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           CE,
  input  logic           CLR,
  input  logic [A_W-1:0] A,
  input  logic [A_W-1:0] B,
  input  logic [C_W-1:0] C,
  output logic [C_W-1:0] Q
);

  localparam bit A_REG  = ConfigBits[CFG_A_REG];
  localparam bit B_REG  = ConfigBits[CFG_B_REG];
  localparam bit C_REG  = ConfigBits[CFG_C_REG];
  localparam bit ACC    = ConfigBits[CFG_ACC];
  localparam bit SIGNED = ConfigBits[CFG_SIGNED];
  localparam bit Q_REG  = ConfigBits[CFG_Q_REG];

  logic [A_W-1:0] a_sel, b_sel;
  logic [C_W-1:0] c_sel, p;

  // Independent input registers: A_REG without B_REG skews the operands by
  // one cycle, matching the hard block.
  muladd_opt_reg #(.W(A_W), .BYPASS(!A_REG)) u_a_reg (
    .clk(CLK), .rst_n(RST_N), .ce(CE), .d(A), .q(a_sel)
  );
  muladd_opt_reg #(.W(A_W), .BYPASS(!B_REG)) u_b_reg (
    .clk(CLK), .rst_n(RST_N), .ce(CE), .d(B), .q(b_sel)
  );
  muladd_opt_reg #(.W(C_W), .BYPASS(!C_REG)) u_c_reg (
    .clk(CLK), .rst_n(RST_N), .ce(CE), .d(C), .q(c_sel)
  );

  always_comb p = prod_ext(a_sel, b_sel, SIGNED);

  generate
    if (ACC) begin : g_acc
      // Output is the accumulator itself, so Q_REG has no effect here.
      logic [C_W-1:0] acc_q, acc_d;

      always_comb begin
        acc_d = acc_q;
        if (CE) acc_d = CLR ? (c_sel + p) : (acc_q + p);
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) acc_q <= '0;
        else        acc_q <= acc_d;
      end

      assign Q = acc_q;
    end else begin : g_add
      logic [C_W-1:0] s;
      logic           unused_clr;

      assign unused_clr = CLR;
      always_comb s = c_sel + p;

      muladd_opt_reg #(.W(C_W), .BYPASS(!Q_REG)) u_q_reg (
        .clk(CLK), .rst_n(RST_N), .ce(CE), .d(s), .q(Q)
      );
    end
  endgenerate

endmodule
